// File: rtl/fifo_read_drain_if.sv
// Downstream valid/ready stream carried out of the read-side drain engine.
//   out_valid : out_data holds a word (driven by master)
//   out_ready : downstream accepts the word this cycle (driven by slave)
//   out_data  : word at the head of the drain buffer (driven by master)
`ifndef DATA
`define DATA 8
`endif

interface fifo_read_drain_if #(
  parameter int DATA = `DATA
);
  logic            out_valid;
  logic            out_ready;
  logic [DATA-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo_read_drain.sv
// Read-side drain engine for the asynchronous FIFO, entirely in the rclk domain.
// Pops show-ahead words from the FIFO read port into a 2-entry buffer and
// presents them downstream as a valid/ready stream.
//   rclk      : read-domain clock, rising edge
//   rrstn     : asynchronous active-low reset
//   rempty    : FIFO empty flag
//   rdata     : FIFO head word, valid while rempty = 0
//   rinc      : FIFO pop request
//   drain_en  : enables popping from the FIFO
//   down      : downstream stream (out_valid / out_ready / out_data)
//   buf_level : buffer occupancy 0..2
//   rd_count  : words delivered downstream, wraps modulo 2^CNT_W
`ifndef DATA
`define DATA 8
`endif

module fifo_read_drain #(
  parameter int DATA  = `DATA,
  parameter int CNT_W = 16
) (
  input  logic               rclk,
  input  logic               rrstn,
  input  logic               rempty,
  input  logic [DATA-1:0]    rdata,
  output logic               rinc,
  input  logic               drain_en,
  fifo_read_drain_if.master  down,
  output logic [1:0]         buf_level,
  output logic [CNT_W-1:0]   rd_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e            occ_q, occ_d;
  logic [DATA-1:0] head_q, head_d;
  logic [DATA-1:0] tail_q, tail_d;
  logic            push;
  logic            pop_out;

  // Pop only while out of reset, enabled, FIFO non-empty and buffer has room.
  // Deliberately no out_ready term: the buffer absorbs one cycle of stall.
  assign rinc    = rrstn & drain_en & ~rempty & (occ_q != OCC_FULL);
  assign push    = rinc;

  assign down.out_valid = (occ_q != OCC_EMPTY);
  assign down.out_data  = head_q;
  assign pop_out        = down.out_valid & down.out_ready;
  assign buf_level      = occ_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d  = OCC_ONE;
          head_d = rdata;
        end
      end
      OCC_ONE: begin
        if (push && pop_out) begin
          // Head leaves and the new word takes its place in one edge.
          head_d = rdata;
        end else if (push) begin
          occ_d  = OCC_FULL;
          tail_d = rdata;
        end else if (pop_out) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // push is impossible here; only the head can leave.
        if (pop_out) begin
          occ_d  = OCC_ONE;
          head_d = tail_q;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the data slots are reset too, because out_data must read 0 in reset.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      occ_q    <= OCC_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      rd_count <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (pop_out) rd_count <= rd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_read_drain.sv
module tb_fifo_read_drain;
  localparam int DATA = 8;

  logic             rclk = 1'b0;
  logic             rrstn = 1'b0;
  logic             rempty;
  logic [DATA-1:0]  rdata;
  logic             drain_en = 1'b0;
  logic             rinc, rinc2;
  logic [1:0]       buf_level, buf_level2;
  logic [15:0]      rd_count;
  logic [3:0]       rd_count2;

  fifo_read_drain_if #(.DATA(DATA)) bus ();
  fifo_read_drain_if #(.DATA(DATA)) bus2 ();
  assign bus2.out_ready = bus.out_ready;

  fifo_read_drain #(.DATA(DATA), .CNT_W(16)) dut (
    .rclk(rclk), .rrstn(rrstn), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .drain_en(drain_en), .down(bus), .buf_level(buf_level), .rd_count(rd_count)
  );

  // Narrow-counter copy driven by identical inputs, used for the wrap check.
  fifo_read_drain #(.DATA(DATA), .CNT_W(4)) dut_w4 (
    .rclk(rclk), .rrstn(rrstn), .rempty(rempty), .rdata(rdata), .rinc(rinc2),
    .drain_en(drain_en), .down(bus2), .buf_level(buf_level2), .rd_count(rd_count2)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA-1:0] fifo_q[$];   // model of the asynchronous FIFO contents
  logic [DATA-1:0] exp_q[$];    // scoreboard: words expected downstream, in order
  int   xfer_t[$];              // cycle stamps of downstream transfers
  bit   pop_pend = 1'b0;
  int   cyc = 0;
  int   pop_cnt = 0;

  function automatic void refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endfunction

  function automatic void write_word(input logic [DATA-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endfunction

  // Monitor: inputs only change on the falling edge, so 1 unit later every
  // signal is settled for the coming rising edge.
  always @(negedge rclk) begin
    logic [DATA-1:0] exp_w;
    #1;
    cyc++;
    pop_pend = (rinc === 1'b1);
    if (rinc === 1'b1) pop_cnt++;
    n_checks++;
    if (rinc === 1'b1 && rempty !== 1'b0) begin
      n_fail++;
      $display("FAIL rinc_while_empty: rinc=%b rempty=%b cycle=%0d", rinc, rempty, cyc);
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      xfer_t.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h, expected none", bus.out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.out_data !== exp_w) begin
          n_fail++;
          $display("FAIL out_data_order: got %h, expected %h", bus.out_data, exp_w);
        end
      end
    end
  end

  // FIFO model: advance just after an edge that saw rinc=1.
  always @(posedge rclk) begin
    #1;
    if (pop_pend && rrstn && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      refresh();
    end
    pop_pend = 1'b0;
  end

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bus.out_valid !== 1'b0) && k < budget) begin
      @(negedge rclk); #2;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words pending, out_valid=%b, expected drained", name, exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrstn = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    @(negedge rclk);
    rrstn = 1'b1;
  endtask

  task automatic test_reset();
    // Power-on reset values.
    repeat (2) @(negedge rclk);
    #2;
    n_checks += 5;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL por_out_valid: got %b, expected 0", bus.out_valid); end
    if (buf_level !== 2'd0) begin n_fail++; $display("FAIL por_buf_level: got %0d, expected 0", buf_level); end
    if (rd_count !== 16'd0) begin n_fail++; $display("FAIL por_rd_count: got %0d, expected 0", rd_count); end
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL por_rinc: got %b, expected 0", rinc); end
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL por_out_data: got %h, expected 0", bus.out_data); end
    @(negedge rclk);
    rrstn = 1'b1;

    // Mid-stream: deliver two words, then stall until the buffer is full.
    drain_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) write_word(DATA'(8'h51 + i));
    repeat (3) @(negedge rclk);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge rclk);
    #2;
    n_checks += 2;
    if (buf_level !== 2'd2) begin n_fail++; $display("FAIL mid_pre_level: got %0d, expected 2", buf_level); end
    if (rd_count !== 16'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d, expected 2", rd_count); end
    #1;
    rrstn = 1'b0;
    #1;
    n_checks += 5;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b, expected 0", bus.out_valid); end
    if (buf_level !== 2'd0) begin n_fail++; $display("FAIL mid_buf_level: got %0d, expected 0", buf_level); end
    if (rd_count !== 16'd0) begin n_fail++; $display("FAIL mid_rd_count: got %0d, expected 0", rd_count); end
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL mid_rinc: got %b, expected 0", rinc); end
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL mid_out_data: got %h, expected 0", bus.out_data); end
    fifo_q.delete();
    exp_q.delete();
    refresh();
    @(negedge rclk);
    rrstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk); #2;
      n_checks++;
      if (rinc !== 1'b0) begin n_fail++; $display("FAIL post_reset_rinc: got %b, expected 0 (cycle %0d)", rinc, i); end
    end
  endtask

  task automatic test_streaming();
    int base;
    @(negedge rclk);
    drain_en = 1'b1;
    bus.out_ready = 1'b1;
    base = xfer_t.size();
    for (int i = 1; i <= 16; i++) write_word(DATA'(i));
    wait_drain("streaming", 100);
    n_checks += 3;
    if (xfer_t.size() - base != 16) begin
      n_fail++; $display("FAIL stream_xfers: got %0d, expected 16", xfer_t.size() - base);
    end else begin
      for (int i = base + 1; i < base + 16; i++) begin
        n_checks++;
        if (xfer_t[i] - xfer_t[i-1] != 1) begin
          n_fail++; $display("FAIL stream_rate: gap %0d cycles at word %0d, expected 1", xfer_t[i] - xfer_t[i-1], i - base);
        end
      end
    end
    if (rd_count !== 16'd16) begin n_fail++; $display("FAIL stream_rd_count: got %0d, expected 16", rd_count); end
    if (rd_count2 !== 4'd0) begin n_fail++; $display("FAIL stream_rd_count_w4: got %0d, expected 0", rd_count2); end
  endtask

  task automatic test_backpressure();
    int p0;
    @(negedge rclk);
    bus.out_ready = 1'b0;
    drain_en = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) write_word(DATA'(8'h21 + i));
    repeat (6) @(negedge rclk);
    #2;
    n_checks += 3;
    if (pop_cnt - p0 != 2) begin n_fail++; $display("FAIL bp_pops: got %0d, expected 2", pop_cnt - p0); end
    if (buf_level !== 2'd2) begin n_fail++; $display("FAIL bp_level: got %0d, expected 2", buf_level); end
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL bp_rinc_held: got %b, expected 0", rinc); end
    @(negedge rclk);
    bus.out_ready = 1'b1;
    #2;
    n_checks++;
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL bp_no_ready_path: got %b, expected 0", rinc); end
    @(negedge rclk); #2;
    n_checks++;
    if (rinc !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b, expected 1", rinc); end
    wait_drain("backpressure", 50);
    n_checks++;
    if (fifo_q.size() != 0) begin n_fail++; $display("FAIL bp_fifo_left: got %0d, expected 0", fifo_q.size()); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] rc0;
    @(negedge rclk);
    bus.out_ready = 1'b0;
    drain_en = 1'b1;
    write_word(8'hAA);
    @(negedge rclk);
    rc0 = rd_count;
    bus.out_ready = 1'b1;
    write_word(8'hBB);
    #2;
    n_checks += 2;
    if (buf_level !== 2'd1) begin n_fail++; $display("FAIL sim_pre_level: got %0d, expected 1", buf_level); end
    if (bus.out_data !== 8'hAA) begin n_fail++; $display("FAIL sim_pre_data: got %h, expected aa", bus.out_data); end
    @(negedge rclk); #2;
    n_checks += 3;
    if (bus.out_data !== 8'hBB) begin n_fail++; $display("FAIL sim_data: got %h, expected bb", bus.out_data); end
    if (buf_level !== 2'd1) begin n_fail++; $display("FAIL sim_level: got %0d, expected 1", buf_level); end
    if (rd_count !== rc0 + 16'd1) begin n_fail++; $display("FAIL sim_count: got %0d, expected %0d", rd_count, rc0 + 16'd1); end
    wait_drain("simultaneous", 20);
  endtask

  task automatic test_drain_gating();
    @(negedge rclk);
    bus.out_ready = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) write_word(DATA'(8'h31 + i));
    repeat (3) @(negedge rclk);
    drain_en = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    n_checks += 2;
    if (buf_level !== 2'd2) begin n_fail++; $display("FAIL gate_pre_level: got %0d, expected 2", buf_level); end
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL gate_rinc_full: got %b, expected 0", rinc); end
    @(negedge rclk); #2;
    n_checks++;
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL gate_rinc_one: got %b, expected 0", rinc); end
    @(negedge rclk); #2;
    n_checks += 3;
    if (buf_level !== 2'd0) begin n_fail++; $display("FAIL gate_level: got %0d, expected 0", buf_level); end
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL gate_rinc_empty: got %b, expected 0", rinc); end
    if (fifo_q.size() != 2) begin n_fail++; $display("FAIL gate_fifo_occ: got %0d, expected 2", fifo_q.size()); end
    @(negedge rclk);
    drain_en = 1'b1;
    #2;
    n_checks++;
    if (rinc !== 1'b1) begin n_fail++; $display("FAIL gate_reenable: got %b, expected 1", rinc); end
    drain_en = 1'b0;
    #1;
    n_checks++;
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL gate_comb_drop: got %b, expected 0", rinc); end
    drain_en = 1'b1;
    #1;
    n_checks++;
    if (rinc !== 1'b1) begin n_fail++; $display("FAIL gate_comb_raise: got %b, expected 1", rinc); end
    wait_drain("gating", 20);
  endtask

  task automatic test_wrap();
    do_reset();
    drain_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) write_word(DATA'(8'h60 + i));
    wait_drain("wrap15", 60);
    n_checks++;
    if (rd_count2 !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d, expected 15", rd_count2); end
    @(negedge rclk);
    write_word(8'h7E);
    wait_drain("wrap16", 20);
    n_checks += 2;
    if (rd_count2 !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d, expected 0", rd_count2); end
    if (rd_count !== 16'd16) begin n_fail++; $display("FAIL wrap_wide: got %0d, expected 16", rd_count); end
    @(negedge rclk);
    write_word(8'h7F);
    wait_drain("wrap17", 20);
    n_checks += 2;
    if (rd_count2 !== 4'd1) begin n_fail++; $display("FAIL wrap_1: got %0d, expected 1", rd_count2); end
    if (buf_level2 !== 2'd0) begin n_fail++; $display("FAIL wrap_level: got %0d, expected 0", buf_level2); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    refresh();
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_drain_gating();
    test_wrap();
    repeat (2) @(negedge rclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_read_drain.md
# fifo_read_drain

Read-side drain engine for the asynchronous FIFO. It sits entirely in the `rclk` domain on the FIFO read port (`rinc`/`rdata`/`rempty`). It pops words into a 2-entry output buffer and presents them downstream as a valid/ready stream, never over-reading an empty FIFO. It is the consumer counterpart to the write-side driver that feeds `winc`/`wdata`.

## Interface
- `DATA`, default `` `DATA `` (from defines.svh): FIFO word width.
- `CNT_W`, default 16: width of the delivered-word counter.

Ports:
- `rclk`  in  1  read-domain clock; all logic is on its rising edge.
- `rrstn`  in  1  reset, asynchronous, active-low.
- `rempty`  in  1  FIFO empty flag, synchronous to `rclk`.
- `rdata`  in  DATA  FIFO show-ahead head word; valid whenever `rempty`=0.
- `rinc`  out  1  FIFO pop request; the FIFO advances on a `rclk` edge with `rinc`=1 and `rempty`=0.
- `drain_en`  in  1  enables popping from the FIFO.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  DATA  buffer head word.
- `buf_level`  out  2  buffer occupancy, 0..2.
- `rd_count`  out  CNT_W  number of words delivered downstream; wraps modulo 2^CNT_W.

## Operation
- **Buffer.** 2-entry FIFO with head/tail slots and an occupancy register `occ` in {0,1,2}. `buf_level` = `occ`.
- **Pop rule (combinational).** `rinc` = `rrstn` & `drain_en` & ~`rempty` & (`occ` != 2).
  - There is no `out_ready`-to-`rinc` path.
  - `rinc` is never 1 while `rempty`=1.
- **Push.** `push` = `rinc`. At the edge, `rdata` is written into the tail slot.
- **Output.** `out_valid` = (`occ` != 0). `out_data` = head slot. `pop_out` = `out_valid` & `out_ready`.
- **Occupancy update per edge.** `occ` += `push` − `pop_out`.
  - When `push` and `pop_out` both occur, order is preserved: the head shifts and the new word lands behind any remaining word.
  - `push` cannot occur at `occ`=2. `pop_out` cannot occur at `occ`=0.
- **Counter.** `rd_count` increments by 1 on every `pop_out` and wraps from all-ones to 0.
- **Occupancy FSM.** `occ` has three states: EMPTY(0), ONE(1), FULL(2).
  - EMPTY -> ONE on `push`.
  - ONE -> FULL on `push` & ~`pop_out`.
  - ONE -> EMPTY on `pop_out` & ~`push`.
  - ONE stays ONE on both or neither.
  - FULL -> ONE on `pop_out`.
- **`drain_en` low.** Popping stops immediately (same cycle, combinational). Buffered words are still delivered downstream.
- **Stability rule.** `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset.** While `rrstn`=0:
  - `occ`=0, `out_valid`=0, `buf_level`=0, `rd_count`=0, `out_data`=0 (slots cleared), `rinc`=0.
  - An asynchronous assertion mid-operation discards buffered words. The FIFO pointer is not touched beyond pops already taken.
  - First possible `rinc`=1 is in the first cycle after `rrstn` rises, subject to the pop rule.
- **Latency.** A word popped at edge N (`rinc`=1) is on `out_data` with `out_valid`=1 from just after edge N. It can be accepted at edge N+1 at the earliest.
- **Throughput.** 1 word/cycle when `drain_en`=1, `rempty`=0 and `out_ready`=1 continuously; steady-state `occ`=1.
- **Backpressure.** With `out_ready`=0 and the FIFO non-empty, exactly 2 words are popped and then `rinc` drops. Popping resumes in the cycle after the first `pop_out`.
- **`rempty` toggles.** `rinc` follows `rempty` combinationally in the same cycle. No pop is issued on a cycle where `rempty`=1.

## Test plan
- **Reset values.** Assert `rrstn`=0 mid-stream with `occ`=2 -> same cycle: `out_valid`=0, `buf_level`=0, `rd_count`=0, `rinc`=0. After release with FIFO empty, `rinc` stays 0.
- **Streaming.** Write 0x01..0x10 into the FIFO; hold `drain_en`=1 and `out_ready`=1 -> `out_data` sequence is 0x01..0x10 at one word per cycle after the first. `rd_count`=16. `rinc` never asserts with `rempty`=1.
- **Backpressure.** 4 words in FIFO, `out_ready`=0 -> exactly 2 `rinc` pulses, then `buf_level`=2 and `rinc`=0. Raise `out_ready` -> the remaining words drain in order with no loss or duplication.
- **Simultaneous push/pop.** `occ`=1 holding 0xAA, `rdata`=0xBB, `out_ready`=1 -> next cycle `out_data`=0xBB, `buf_level`=1, `rd_count` +1.
- **`drain_en` gating.** With `occ`=2, drop `drain_en` -> `rinc`=0 in the same cycle. The 2 buffered words still deliver and `buf_level` reaches 0. FIFO occupancy is unchanged.
- **Wrap.** `CNT_W`=4, deliver 17 words -> `rd_count` reads 15 then 0 then 1.
